// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-confirm types: queue entries, resolve results and
// common constants used by the fetch and confirm stages.
package branch_resolve_unit_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic RESET = 1'b1;

    localparam int ADDR_W     = 32;
    localparam int INSN_BYTES = 4;

    typedef struct packed {
        logic              taken;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
    } branch_queue_entry_t;

    typedef struct packed {
        logic              is_branch;
        logic              is_branch_taken;
        logic              redirect;
        logic [ADDR_W-1:0] redirect_pc;
    } branch_resolve_result_t;

endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// In-order FIFO of fetch-side branch predictions awaiting resolution.
// Clear has priority over push/pop so wrong-path entries never survive.
module branch_pred_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    assign head_data = mem[head];
    assign empty     = (count == '0);

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Confirm-stage branch resolution: compares the oldest prediction with
// the actual outcome and emits training, redirect, flush and counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic                  pred_taken,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    output logic                  pred_ready,
    input  logic                  res_valid,
    input  logic                  res_taken,
    input  logic [ADDR_WIDTH-1:0] res_target,
    output logic                  upd_is_branch,
    output logic                  upd_taken,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count,
    output logic                  err_underflow
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    branch_queue_entry_t    push_entry;
    branch_queue_entry_t    head;
    branch_resolve_result_t res_q;
    logic [CW-1:0]          count;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   mispredict;
    logic                   clear;

    assign push_entry = '{taken: pred_taken, pc: pred_pc, target: pred_target};

    // Ready comes from registered state only; held low during flush
    assign pred_ready = (count < CW'(QUEUE_DEPTH)) && !res_q.redirect;
    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && !empty;
    assign mispredict = (head.taken != res_taken)
                     || (res_taken && head.target != res_target);
    assign clear      = pop && mispredict;

    branch_pred_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(branch_queue_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (clear),
        .head_data (head),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            res_q            <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            err_underflow    <= FALSE;
        end else begin
            res_q.is_branch       <= pop;
            res_q.is_branch_taken <= pop && res_taken;
            res_q.redirect        <= clear;
            res_q.redirect_pc     <= '0;
            if (clear) begin
                res_q.redirect_pc <= res_taken ? res_target
                                   : head.pc + ADDR_W'(INSN_BYTES);
            end
            if (pop) begin
                branch_count <= branch_count + CNT_WIDTH'(1);
            end
            if (clear) begin
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
            end
            if (res_valid && empty) begin
                err_underflow <= TRUE;
            end
        end
    end

    assign upd_is_branch  = res_q.is_branch;
    assign upd_taken      = res_q.is_branch_taken;
    assign redirect_valid = res_q.redirect;
    assign flush          = res_q.redirect;
    assign redirect_pc    = res_q.redirect_pc;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit against a queue-based
// reference model, with directed scenarios and a randomized phase.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_pc = '0;
    logic [31:0] pred_target = '0;
    logic        pred_ready;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        upd_is_branch;
    logic        upd_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    logic        err_underflow;

    branch_resolve_unit #(
        .QUEUE_DEPTH (DEPTH),
        .ADDR_WIDTH  (32),
        .CNT_WIDTH   (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_pc          (pred_pc),
        .pred_target      (pred_target),
        .pred_ready       (pred_ready),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .upd_is_branch    (upd_is_branch),
        .upd_taken        (upd_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .err_underflow    (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        t;
        bit [31:0] pc;
        bit [31:0] tg;
    } ent_t;

    typedef struct {
        bit          taken;
        bit          mis;
        bit [31:0]   rpc;
        int unsigned bc;
        int unsigned mc;
    } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    bit          mflush;
    bit          merr;
    int unsigned mbc;
    int unsigned mmc;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every update pulse must match the oldest expected resolve
    always @(negedge clk) begin
        if (upd_is_branch === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_upd", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("upd_taken", upd_taken, e.taken);
                chk("redirect_valid", redirect_valid, e.mis);
                chk("flush", flush, e.mis);
                chk("redirect_pc", redirect_pc, e.rpc);
                chk("branch_count", branch_count, e.bc);
                chk("mispredict_count", mispredict_count, e.mc);
            end
        end else if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
            chk("redirect_without_upd", {redirect_valid, flush}, 0);
        end
    end

    task automatic cyc(input bit pv, input bit pt, input bit [31:0] ppc,
                       input bit [31:0] ptg, input bit rv, input bit rt,
                       input bit [31:0] rtg);
        bit   ready;
        bit   mis;
        ent_t e;
        @(negedge clk);
        pred_valid  = pv;
        pred_taken  = pt;
        pred_pc     = ppc;
        pred_target = ptg;
        res_valid   = rv;
        res_taken   = rt;
        res_target  = rtg;
        ready = (mq.size() < DEPTH) && !mflush;
        chk("pred_ready", pred_ready, ready);
        mis = 1'b0;
        if (rv) begin
            if (mq.size() == 0) begin
                merr = 1'b1;
            end else begin
                e   = mq.pop_front();
                mis = (e.t != rt) || (rt && e.tg != rtg);
                mbc++;
                if (mis) mmc++;
                sb.push_back('{rt, mis, mis ? (rt ? rtg : e.pc + 32'd4) : 32'd0,
                               mbc, mmc});
                if (mis) mq.delete();
            end
        end
        if (pv && ready && !mis) mq.push_back('{pt, ppc, ptg});
        mflush = mis;
        @(posedge clk);
        #1;
        chk("err_underflow", err_underflow, merr);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input bit t, input bit [31:0] pc, input bit [31:0] tg);
        cyc(1, t, pc, tg, 0, 0, 0);
    endtask

    // Resolve the current head correctly, optionally pushing alongside
    task automatic resolve_ok(input bit pv, input bit [31:0] ppc);
        cyc(pv, ppc[2], ppc, ppc + 32'h40, 1, mq[0].t, mq[0].tg);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst        = 1'b1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        mq.delete();
        mflush = 1'b0;
        merr   = 1'b0;
        mbc    = 0;
        mmc    = 0;
        chk("rst_outputs", {upd_is_branch, upd_taken, redirect_valid, flush,
                            err_underflow}, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_counters", {branch_count, mispredict_count}, 0);
        chk("rst_pred_ready", pred_ready, 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset(2);

        push(1, 32'h100, 32'h200);
        cyc(0, 0, 0, 0, 1, 1, 32'h200);
        idle();

        push(0, 32'h104, 32'h500);
        cyc(0, 0, 0, 0, 1, 1, 32'h300);
        cyc(1, 1, 32'h900, 32'h904, 0, 0, 0);
        idle();

        push(1, 32'h108, 32'h400);
        cyc(1, 1, 32'h10C, 32'h600, 1, 0, 0);
        idle();
        idle();

        for (int i = 0; i < DEPTH + 1; i++) begin
            push(i[0], 32'h1000 + 32'(i) * 4, 32'h1040 + 32'(i) * 4);
        end
        resolve_ok(1, 32'h2000);
        for (int i = 0; i < 8; i++) begin
            resolve_ok(1, 32'h3000 + 32'(i) * 4);
        end
        while (mq.size() > 0) resolve_ok(0, 0);
        idle();

        for (int i = 0; i < DEPTH; i++) begin
            push(1, 32'h4000 + 32'(i) * 4, 32'h5000);
        end
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 1, 1, 32'h5000);
        idle();
        idle();

        push(1, 32'h6000, 32'h6100);
        push(0, 32'h6004, 32'h6200);
        do_reset(1);

        for (int n = 0; n < 600; n++) begin
            bit        pv;
            bit        rv;
            bit        rt;
            bit [31:0] rtg;
            bit [31:0] pc;
            pv  = ($urandom % 2) == 1;
            rv  = (mq.size() > 0) && (($urandom % 2) == 1);
            pc  = $urandom & 32'hFFFF_FFFC;
            rt  = 1'b0;
            rtg = 32'd0;
            if (rv) begin
                rt  = (($urandom % 4) == 0) ? ~mq[0].t : mq[0].t;
                rtg = (($urandom % 5) == 0) ? $urandom : mq[0].tg;
            end
            cyc(pv, pc[3], pc, $urandom, rv, rt, rtg);
        end
        repeat (3) idle();
        chk("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
